// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls a PIO input register at a fixed cadence
// and debounces the low DATA_W bits into a stable level plus a change strobe.
module pio_poll_master #(
  parameter int DATA_W       = 2,
  parameter int ADDR_W       = 2,
  parameter int POLL_ADDR    = 0,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] stable_out,
  output logic              change_pulse,
  output logic [15:0]       poll_count
);

  localparam int TIMER_W = $clog2(POLL_DIV);
  localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CNT_W   = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
  localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0]   LAT_ONE    = LAT_W'(1);
  localparam logic [LAT_W-1:0]   LAT_ZERO   = LAT_W'(0);
  localparam logic [CNT_W-1:0]   MATCH_MAX  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0]   MATCH_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   MATCH_ZERO = CNT_W'(0);
  localparam logic [DATA_W-1:0]  DATA_ZERO  = DATA_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EVAL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    match_q, match_d;
  logic [DATA_W-1:0]   stable_q, stable_d;
  logic                pulse_q, pulse_d;
  logic                read_q, read_d;
  logic [15:0]         count_q, count_d;
  logic                unused_hi_s;

  assign avm_address  = ADDR_W'(POLL_ADDR);
  assign avm_read     = read_q;
  assign stable_out   = stable_q;
  assign change_pulse = pulse_q;
  assign poll_count   = count_q;
  assign unused_hi_s  = ^avm_readdata[31:DATA_W];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= TIMER_ZERO;
      lat_q    <= LAT_ZERO;
      sample_q <= DATA_ZERO;
      cand_q   <= DATA_ZERO;
      match_q  <= MATCH_ZERO;
      stable_q <= DATA_ZERO;
      pulse_q  <= 1'b0;
      read_q   <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lat_q    <= lat_d;
      sample_q <= sample_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      read_q   <= read_d;
      count_q  <= count_d;
    end
  end

  // Poll sequencing, sample capture and debounce update.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    lat_d    = lat_q;
    sample_d = sample_q;
    cand_d   = cand_q;
    match_d  = match_q;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (timer_q == TIMER_LAST) begin
            timer_d = TIMER_ZERO;
            state_d = ST_REQ;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end else begin
          timer_d = TIMER_ZERO;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          lat_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_ZERO) begin
          sample_d = avm_readdata[DATA_W-1:0];
          count_d  = count_q + 16'h0001;
          state_d  = ST_EVAL;
        end else begin
          lat_d = lat_q - LAT_ONE;
        end
      end
      ST_EVAL: begin
        if (sample_q == cand_q) begin
          if (match_q < MATCH_MAX) begin
            match_d = match_q + MATCH_ONE;
          end else begin
            match_d = MATCH_MAX;
          end
        end else begin
          cand_d  = sample_q;
          match_d = MATCH_ONE;
        end
        // Qualify on the post-update count so the Nth identical sample commits.
        if ((match_d >= MATCH_MAX) && (cand_d != stable_q)) begin
          stable_d = cand_d;
          pulse_d  = 1'b1;
        end else begin
          stable_d = stable_q;
          pulse_d  = 1'b0;
        end
        timer_d = TIMER_ZERO;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    read_d = (state_d == ST_REQ);
  end

endmodule

// File: tb/tb_pio_poll_master.sv
// Self-checking bench for pio_poll_master: a cycle-level timeline model of the
// poll/debounce rules, a responding PIO slave, and directed plus random phases.
module tb_pio_poll_master;

  localparam int POLL_DIV = 8;
  localparam int DC       = 3;

  logic        clk = 1'b0;
  logic        reset, enable, sel, waitreq;
  logic [31:0] rdata;
  logic        enable_a, enable_b;
  logic [1:0]  addr_a, addr_b, stable_a, stable_b;
  logic        read_a, read_b, pulse_a, pulse_b;
  logic [15:0] count_a, count_b;
  logic        dut_read, dut_pulse;
  logic [1:0]  dut_stable;
  logic [15:0] dut_count;

  always #5 clk = ~clk;

  assign enable_a   = enable & ~sel;
  assign enable_b   = enable & sel;
  assign dut_read   = sel ? read_b   : read_a;
  assign dut_pulse  = sel ? pulse_b  : pulse_a;
  assign dut_stable = sel ? stable_b : stable_a;
  assign dut_count  = sel ? count_b  : count_a;

  pio_poll_master #(.DATA_W(2), .ADDR_W(2), .POLL_ADDR(0), .POLL_DIV(POLL_DIV),
                    .READ_LATENCY(1), .DEBOUNCE_CNT(DC)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .avm_address(addr_a),
    .avm_read(read_a), .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .stable_out(stable_a), .change_pulse(pulse_a), .poll_count(count_a));

  pio_poll_master #(.DATA_W(2), .ADDR_W(2), .POLL_ADDR(0), .POLL_DIV(POLL_DIV),
                    .READ_LATENCY(3), .DEBOUNCE_CNT(DC)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .avm_address(addr_b),
    .avm_read(read_b), .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .stable_out(stable_b), .change_pulse(pulse_b), .poll_count(count_b));

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // slave state
  logic [31:0] vals[$];
  logic [31:0] slave_val = 32'h0;
  int  cd = 0, stall_left = 0, next_stall = 0;
  bit  rand_stall = 1'b0;
  logic prev_read = 1'b0, prev_wr = 1'b0, prev_en = 1'b0, prev_reset = 1'b1;

  // reference model state
  bit   m_read = 1'b0, m_idle = 1'b1, m_pend = 1'b0, m_pulse = 1'b0;
  int   m_idle_run = 0, m_acc = 0, m_run = 0, m_evals = 0;
  logic [31:0] m_val = 32'h0;
  logic [15:0] m_count = 16'h0;
  logic [1:0]  m_stable = 2'b0, m_cand = 2'b0;

  // observations
  int pulse_seen = 0, rise_count = 0, last_rise = 0, prev_rise = 0, read_len = 0, cur_len = 0;

  function automatic int lat();
    return sel ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cycle);
    end
  endtask

  task automatic step();
    logic [31:0] r;
    prev_read  = dut_read;
    prev_wr    = waitreq;
    prev_en    = enable;
    prev_reset = reset;
    @(posedge clk);
    #1;
    cycle++;

    // slave: respond READ_LATENCY cycles after each accepted read, garbage otherwise
    if (prev_read && !prev_wr) begin
      if (vals.size() > 0) begin
        slave_val = vals.pop_front();
      end else begin
        r = $urandom();
        if ($urandom_range(0, 2) != 0) r = (r & 32'hFFFF_FFFC) | (slave_val & 32'h3);
        slave_val = r;
      end
      cd = lat();
    end
    if (cd > 0) begin
      cd--;
      rdata = (cd == 0) ? slave_val : (($urandom() & 32'hFFFF_FFFC) | (~slave_val & 32'h3));
    end else begin
      rdata = ($urandom() & 32'hFFFF_FFFC) | (~slave_val & 32'h3);
    end

    // reference model
    if (prev_reset) begin
      m_read = 1'b0; m_idle = 1'b1; m_idle_run = 0; m_pend = 1'b0; m_pulse = 1'b0;
      m_count = 16'h0; m_stable = 2'b0; m_cand = 2'b0; m_run = 0;
    end else begin
      m_pulse = 1'b0;
      if (m_read && !prev_wr) begin
        m_read = 1'b0; m_pend = 1'b1; m_acc = cycle; m_val = slave_val;
      end
      if (m_idle) begin
        if (prev_en) begin
          m_idle_run++;
          if (m_idle_run == POLL_DIV) begin
            m_idle = 1'b0; m_read = 1'b1; m_idle_run = 0;
          end
        end else begin
          m_idle_run = 0;
        end
      end
      if (m_pend && cycle == m_acc + lat()) m_count = m_count + 16'h1;
      if (m_pend && cycle == m_acc + lat() + 1) begin
        if (m_val[1:0] == m_cand) begin
          if (m_run < DC) m_run++;
        end else begin
          m_cand = m_val[1:0];
          m_run  = 1;
        end
        if (m_run >= DC && m_cand != m_stable) begin
          m_stable = m_cand;
          m_pulse  = 1'b1;
        end
        m_pend = 1'b0; m_idle = 1'b1; m_idle_run = 0; m_evals++;
      end
    end

    chk("avm_read", dut_read, m_read);
    chk("stable_out", dut_stable, m_stable);
    chk("change_pulse", dut_pulse, m_pulse);
    chk("poll_count", dut_count, m_count);

    if (dut_read && !prev_read) begin
      prev_rise = last_rise; last_rise = cycle; cur_len = 0; rise_count++;
      stall_left = rand_stall ? $urandom_range(0, 2) : next_stall;
    end
    if (dut_read) cur_len++;
    if (!dut_read && prev_read) read_len = cur_len;
    if (dut_pulse) pulse_seen++;

    if (dut_read && stall_left > 0) begin
      waitreq = 1'b1;
      stall_left--;
    end else begin
      waitreq = 1'b0;
    end
  endtask

  task automatic wait_evals(input int n, input int budget);
    int k = 0;
    while (m_evals < n && k < budget) begin
      step();
      k++;
    end
    chk("poll_progress", (m_evals >= n), 1'b1);
  endtask

  initial begin
    int base, en_cycle, rc, k;
    logic [15:0] c0;
    reset = 1'b1; enable = 1'b0; sel = 1'b0; waitreq = 1'b0; rdata = 32'h0;

    // reset and long disabled idle
    repeat (3) step();
    reset = 1'b0;
    repeat (50) step();
    chk("idle_count", dut_count, 16'h0);
    chk("idle_stable", dut_stable, 2'b0);
    chk("idle_no_read", rise_count, 0);
    chk("address", addr_a, 2'b0);

    // cadence and debounce accept
    repeat (4) vals.push_back(32'h2);
    base = m_evals; pulse_seen = 0;
    enable = 1'b1; en_cycle = cycle;
    wait_evals(base + 1, 40);
    chk("first_launch", last_rise - en_cycle, POLL_DIV);
    chk("read_len", read_len, 1);
    wait_evals(base + 2, 40);
    chk("launch_spacing", last_rise - prev_rise, POLL_DIV + 3);
    wait_evals(base + 3, 40);
    chk("accept_stable", dut_stable, 2'h2);
    chk("accept_pulses", pulse_seen, 1);
    wait_evals(base + 4, 40);
    chk("no_repulse", pulse_seen, 1);

    // bounce reject then accept
    enable = 1'b0; reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    vals.push_back(32'h1); vals.push_back(32'h1); vals.push_back(32'h0);
    vals.push_back(32'h1); vals.push_back(32'h1); vals.push_back(32'h0);
    repeat (3) vals.push_back(32'h3);
    base = m_evals; pulse_seen = 0; enable = 1'b1;
    wait_evals(base + 6, 200);
    chk("bounce_stable", dut_stable, 2'h0);
    chk("bounce_pulses", pulse_seen, 0);
    wait_evals(base + 9, 100);
    chk("bounce_accept", dut_stable, 2'h3);
    chk("bounce_accept_pulses", pulse_seen, 1);

    // waitrequest stall of 5 cycles
    next_stall = 5; base = m_evals; c0 = dut_count;
    wait_evals(base + 1, 60);
    chk("stall_read_len", read_len, 6);
    chk("stall_count", dut_count, c0 + 16'h1);
    next_stall = 0;

    // random samples, stalls and enable drops
    rand_stall = 1'b1;
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      step();
    end
    rand_stall = 1'b0; enable = 1'b1;

    // reset during WAIT
    k = 0;
    while (!(m_pend && cycle == m_acc) && k < 80) begin
      step();
      k++;
    end
    chk("reached_wait", (m_pend && cycle == m_acc), 1'b1);
    reset = 1'b1;
    step();
    chk("rst_read", dut_read, 1'b0);
    chk("rst_stable", dut_stable, 2'b0);
    chk("rst_count", dut_count, 16'h0);
    reset = 1'b0; rc = cycle; k = 0;
    while (last_rise <= rc && k < 40) begin
      step();
      k++;
    end
    chk("resume_launch", last_rise - rc, POLL_DIV);

    // READ_LATENCY=3 instance, upper bits set
    reset = 1'b1; enable = 1'b0;
    step();
    sel = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) vals.push_back(32'hFFFF_FFFD);
    base = m_evals; pulse_seen = 0; enable = 1'b1;
    wait_evals(base + 3, 120);
    chk("lat3_stable", dut_stable, 2'h1);
    chk("lat3_pulses", pulse_seen, 1);
    chk("lat3_count", dut_count, 16'h3);
    chk("lat3_spacing", last_rise - prev_rise, POLL_DIV + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
